// File: rtl/ocmem_dp.sv
// Dual-port on-chip memory: port A read/write with byte lanes, port B read-only.
// Adds a post-reset clear sequencer, optional output register and out-of-range detection.
module ocmem_dp #(
    parameter int MEM_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int MEM_DEPTH    = 1024,
    parameter int BE_WIDTH     = (MEM_WIDTH + 7) / 8,
    parameter int RW_MODE      = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_ce_i,
    input  logic                  a_we_i,
    input  logic [BE_WIDTH-1:0]   a_be_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [MEM_WIDTH-1:0]  a_d_i,
    output logic [MEM_WIDTH-1:0]  a_q_o,
    output logic                  a_vld_o,
    input  logic                  b_ce_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic [MEM_WIDTH-1:0]  b_q_o,
    output logic                  b_vld_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(MEM_DEPTH - 1);

    generate
        if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("ocmem_dp: MEM_DEPTH must be in 1 .. 2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic                    busy_reg;
    logic                    err_reg;

    logic [MEM_WIDTH-1:0]    mem_reg [MEM_DEPTH];

    logic                    accept;
    logic                    clearing;
    logic                    a_oor;
    logic                    b_oor;
    logic                    a_wr_ok;
    logic                    a_rd_en;
    logic                    b_rd_en;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        a_idx;
    logic [IDX_W-1:0]        b_idx;
    logic [MEM_WIDTH-1:0]    wr_data;
    logic [BE_WIDTH-1:0]     wr_be;
    logic [MEM_WIDTH-1:0]    wr_mask;

    logic [MEM_WIDTH-1:0]    a_q1_reg;
    logic                    a_vld1_reg;
    logic [MEM_WIDTH-1:0]    b_q1_reg;
    logic                    b_vld1_reg;

    // Accesses sampled on the same edge as rst_i are dropped so nothing leaks out of reset.
    assign accept   = (state_reg == ST_READY) && !rst_i;
    assign clearing = (state_reg == ST_CLEAR);
    assign a_oor    = {1'b0, a_addr_i} >= DEPTH_C;
    assign b_oor    = {1'b0, b_addr_i} >= DEPTH_C;
    assign a_wr_ok  = accept && a_ce_i && a_we_i && !a_oor;
    assign a_rd_en  = accept && a_ce_i && (!a_we_i || (RW_MODE != 2));
    assign b_rd_en  = accept && b_ce_i;

    assign a_idx    = a_addr_i[IDX_W-1:0];
    assign b_idx    = b_addr_i[IDX_W-1:0];
    assign wr_en    = clearing || a_wr_ok;
    assign wr_idx   = clearing ? cnt_reg[IDX_W-1:0] : a_idx;
    assign wr_data  = clearing ? '0 : a_d_i;
    assign wr_be    = clearing ? '1 : a_be_i;

    genvar gi;
    generate
        for (gi = 0; gi < MEM_WIDTH; gi++) begin : g_mask
            assign wr_mask[gi] = wr_be[gi / 8];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_RESET;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    cnt_reg <= '0;
                    if (CLEAR_ON_RST != 0) begin
                        state_reg <= ST_CLEAR;
                    end else begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_reg == LAST_C) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_READY: begin
                    if (accept && ((a_ce_i && a_oor) || (b_ce_i && b_oor))) begin
                        err_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_RESET;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < MEM_WIDTH; b++) begin
                if (wr_mask[b]) begin
                    mem_reg[wr_idx][b] <= wr_data[b];
                end
            end
        end
    end

    // Reads see the array before this edge's write; write-first merges the new lanes in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q1_reg   <= '0;
            a_vld1_reg <= 1'b0;
            b_q1_reg   <= '0;
            b_vld1_reg <= 1'b0;
        end else begin
            a_vld1_reg <= a_rd_en;
            b_vld1_reg <= b_rd_en;
            if (a_rd_en) begin
                if (a_oor) begin
                    a_q1_reg <= '0;
                end else if (a_we_i && (RW_MODE == 0)) begin
                    a_q1_reg <= (mem_reg[a_idx] & ~wr_mask) | (a_d_i & wr_mask);
                end else begin
                    a_q1_reg <= mem_reg[a_idx];
                end
            end
            if (b_rd_en) begin
                b_q1_reg <= b_oor ? '0 : mem_reg[b_idx];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [MEM_WIDTH-1:0] a_q2_reg;
            logic                 a_vld2_reg;
            logic [MEM_WIDTH-1:0] b_q2_reg;
            logic                 b_vld2_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q2_reg   <= '0;
                    a_vld2_reg <= 1'b0;
                    b_q2_reg   <= '0;
                    b_vld2_reg <= 1'b0;
                end else begin
                    a_vld2_reg <= a_vld1_reg;
                    b_vld2_reg <= b_vld1_reg;
                    if (a_vld1_reg) begin
                        a_q2_reg <= a_q1_reg;
                    end
                    if (b_vld1_reg) begin
                        b_q2_reg <= b_q1_reg;
                    end
                end
            end

            assign a_q_o   = a_q2_reg;
            assign a_vld_o = a_vld2_reg;
            assign b_q_o   = b_q2_reg;
            assign b_vld_o = b_vld2_reg;
        end else begin : g_no_out_reg
            assign a_q_o   = a_q1_reg;
            assign a_vld_o = a_vld1_reg;
            assign b_q_o   = b_q1_reg;
            assign b_vld_o = b_vld1_reg;
        end
    endgenerate

    assign busy_o = busy_reg;
    assign err_o  = err_reg;

endmodule
